cmd_word_fifo: RTL and testbench

CMD_WORD_FIFO -- requirements
Module: cmd_word_fifo

---
 rtl/cmd_word_fifo.sv | 158 +++++++++++++++
 tb/tb_cmd_word_fifo.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_word_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_word_fifo
//  Purpose  : First-word-fall-through command FIFO between the UART command
//             decoder (writer) and the Wishbone master (reader). Holds
//             2**AW command words of DW bits. A write into a full FIFO is
//             dropped and flagged on a sticky overflow flag.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk        in   1     system clock, rising edge
//    i_reset_n    in   1     asynchronous assert, active-low reset
//    i_wr_stb     in   1     upstream word valid (single-cycle strobe)
//    i_wr_word    in   DW    upstream command word
//    o_wr_busy    out  1     FIFO full, write not accepted
//    o_rd_stb     out  1     head word valid
//    o_rd_word    out  DW    head word
//    i_rd_busy    in   1     downstream busy, head not consumed while high
//    o_fill       out  AW+1  words stored, 0..2**AW
//    o_ovf        out  1     sticky: a write was dropped while full
//    i_ovf_clear  in   1     clears o_ovf and o_ovf_cnt
//    o_ovf_cnt    out  8     dropped-word count (saturating)
// ----------------------------------------------------------------------------
//  Build option
//    CMD_FIFO_OVF_CNT_EN  defined   : o_ovf_cnt counts dropped writes,
//                                     saturating at 255.
//                         undefined : o_ovf_cnt is tied to zero.
// ============================================================================
module cmd_word_fifo #(
  parameter int DW = 34,
  parameter int AW = 4
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_wr_stb,
  input  logic [DW-1:0] i_wr_word,
  output logic          o_wr_busy,
  output logic          o_rd_stb,
  output logic [DW-1:0] o_rd_word,
  input  logic          i_rd_busy,
  output logic [AW:0]   o_fill,
  output logic          o_ovf,
  input  logic          i_ovf_clear,
  output logic [7:0]    o_ovf_cnt
);

  localparam int c_DEPTH = 2**AW;

  // Storage is intentionally not reset; its content is only observable
  // while the FIFO holds at least one word.
  logic [DW-1:0] mem_q [c_DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // without a separate counter.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        ovf_q,    ovf_d;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_xfer;
  logic w_drop;

  // --------------------------------------------------------------------------
  // Status, derived from registered pointers only
  // --------------------------------------------------------------------------
  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Full is judged on pre-edge state, so a write arriving while full is
  // dropped even if the head is consumed in the same cycle.
  assign w_wr_acc  = i_wr_stb && !w_full;
  assign w_drop    = i_wr_stb &&  w_full;
  // An empty FIFO has no head, so a write into it is never read the same edge.
  assign w_rd_xfer = !w_empty && !i_rd_busy;

  // --------------------------------------------------------------------------
  // Next-state
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (w_rd_xfer) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // A drop in the same cycle as a clear must still leave the flag set.
  always_comb begin
    ovf_d = w_drop || (ovf_q && !i_ovf_clear);
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_acc) begin
      mem_q[wr_ptr_q[AW-1:0]] <= i_wr_word;
    end
  end

  // --------------------------------------------------------------------------
  // Optional dropped-word counter
  // --------------------------------------------------------------------------
`ifdef CMD_FIFO_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  // Clear has priority over a simultaneous drop; count saturates at 255.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (i_ovf_clear) begin
      ovf_cnt_d = 8'd0;
    end else if (w_drop && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ovf_cnt_q <= 8'd0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign o_ovf_cnt = ovf_cnt_q;
`else
  assign o_ovf_cnt = 8'd0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_fill    = wr_ptr_q - rd_ptr_q;
  assign o_wr_busy = w_full;
  assign o_rd_stb  = !w_empty;
  assign o_rd_word = mem_q[rd_ptr_q[AW-1:0]];
  assign o_ovf     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_word_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmd_word_fifo
//  Purpose  : Self-checking bench for cmd_word_fifo. A queue-based model is
//             compared against the DUT every falling edge; directed
//             sequences add literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_word_fifo;

  localparam int DW = 34;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic          wr_stb;
  logic [DW-1:0] wr_word;
  logic          wr_busy;
  logic          rd_stb;
  logic [DW-1:0] rd_word;
  logic          rd_busy;
  logic [AW:0]   fill;
  logic          ovf;
  logic          ovf_clear;
  logic [7:0]    ovf_cnt;

  int checks = 0;
  int errors = 0;

  cmd_word_fifo #(.DW(DW), .AW(AW)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_wr_stb    (wr_stb),
    .i_wr_word   (wr_word),
    .o_wr_busy   (wr_busy),
    .o_rd_stb    (rd_stb),
    .o_rd_word   (rd_word),
    .i_rd_busy   (rd_busy),
    .o_fill      (fill),
    .o_ovf       (ovf),
    .i_ovf_clear (ovf_clear),
    .o_ovf_cnt   (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: a queue of stored words plus overflow flag/counter
  // --------------------------------------------------------------------------
  logic [DW-1:0] mq[$];
  bit            m_ovf = 1'b0;
  int            m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_cnt = 0;
    end else begin
      bit was_full, do_rd, drop;
      was_full = (mq.size() == DEPTH);
      do_rd    = (mq.size() != 0) && !rd_busy;
      drop     = wr_stb && was_full;
      if (do_rd) void'(mq.pop_front());
      if (wr_stb && !was_full) mq.push_back(wr_word);
      m_ovf = drop || (m_ovf && !ovf_clear);
`ifdef CMD_FIFO_OVF_CNT_EN
      if (ovf_clear) m_cnt = 0;
      else if (drop && m_cnt < 255) m_cnt = m_cnt + 1;
`endif
    end
  end

  always @(negedge clk) begin
    chk("cyc_fill",    64'(fill),    64'(mq.size()));
    chk("cyc_rd_stb",  64'(rd_stb),  64'(mq.size() != 0));
    chk("cyc_wr_busy", 64'(wr_busy), 64'(mq.size() == DEPTH));
    chk("cyc_ovf",     64'(ovf),     64'(m_ovf));
    chk("cyc_ovf_cnt", 64'(ovf_cnt), 64'(m_cnt));
    if (mq.size() != 0) chk("cyc_rd_word", 64'(rd_word), 64'(mq[0]));
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_cnt;

  initial begin
    rst_n = 1'b0; wr_stb = 1'b0; wr_word = '0; rd_busy = 1'b0; ovf_clear = 1'b0;
    tick(); tick();
    chk("rst_fill", 64'(fill), 64'd0);
    chk("rst_stb",  64'(rd_stb), 64'd0);
    chk("rst_busy", 64'(wr_busy), 64'd0);
    chk("rst_ovf",  64'(ovf), 64'd0);
    chk("rst_cnt",  64'(ovf_cnt), 64'd0);
    rst_n = 1'b1;

    // Single word: visible the cycle after the write, gone the cycle after.
    wr_stb = 1'b1; wr_word = 34'h1_0000_00AA;
    tick();
    wr_stb = 1'b0;
    chk("single_stb",  64'(rd_stb), 64'd1);
    chk("single_word", 64'(rd_word), 64'h1_0000_00AA);
    chk("single_fill", 64'(fill), 64'd1);
    tick();
    chk("single_empty_fill", 64'(fill), 64'd0);
    chk("single_empty_stb",  64'(rd_stb), 64'd0);

    // Fill to 16 with reader stalled, then one overflowing write.
    rd_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_stb = 1'b1; wr_word = 34'(i);
      tick();
    end
    wr_stb = 1'b0;
    chk("full_fill", 64'(fill), 64'd16);
    chk("full_busy", 64'(wr_busy), 64'd1);
    chk("full_ovf0", 64'(ovf), 64'd0);
    wr_stb = 1'b1; wr_word = 34'd99;
    tick();
    wr_stb = 1'b0;
`ifdef CMD_FIFO_OVF_CNT_EN
    exp_cnt = 1;
`else
    exp_cnt = 0;
`endif
    chk("ovf17_ovf",  64'(ovf), 64'd1);
    chk("ovf17_cnt",  64'(ovf_cnt), 64'(exp_cnt));
    chk("ovf17_fill", 64'(fill), 64'd16);
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    chk("clear_ovf", 64'(ovf), 64'd0);
    rd_busy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", 64'(rd_word), 64'(i));
      tick();
    end
    chk("drain_empty", 64'(rd_stb), 64'd0);

    // Fill 15, then 40 cycles of simultaneous read+write across wrap.
    rd_busy = 1'b1;
    for (int i = 0; i < 15; i++) begin
      wr_stb = 1'b1; wr_word = 34'(100 + i);
      tick();
    end
    rd_busy = 1'b0;
    for (int k = 0; k < 40; k++) begin
      chk("stream_head", 64'(rd_word), (k < 15) ? 64'(100 + k) : 64'(200 + k - 15));
      wr_stb = 1'b1; wr_word = 34'(200 + k);
      tick();
      chk("stream_fill", 64'(fill), 64'd15);
    end
    wr_stb = 1'b0;
    repeat (15) tick();
    chk("stream_empty", 64'(fill), 64'd0);

    // Full FIFO, read and write on the same edge: write dropped.
    rd_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_stb = 1'b1; wr_word = 34'(300 + i);
      tick();
    end
    rd_busy = 1'b0; wr_stb = 1'b1; wr_word = 34'h3_DEAD_BEEF;
    tick();
    wr_stb = 1'b0;
    chk("rw_full_fill", 64'(fill), 64'd15);
    chk("rw_full_ovf",  64'(ovf), 64'd1);
    for (int k = 0; k < 15; k++) begin
      chk("rw_full_order", 64'(rd_word), 64'(301 + k));
      tick();
    end
    chk("rw_full_empty", 64'(rd_stb), 64'd0);

    // Fill 8 (overflow flag still set), reset mid-cycle.
    rd_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_stb = 1'b1; wr_word = 34'(400 + i);
      tick();
    end
    wr_stb = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_stb",  64'(rd_stb), 64'd0);
    chk("async_rst_fill", 64'(fill), 64'd0);
    chk("async_rst_ovf",  64'(ovf), 64'd0);
    chk("async_rst_cnt",  64'(ovf_cnt), 64'd0);
    tick();
    rst_n = 1'b1; rd_busy = 1'b0;
    wr_stb = 1'b1; wr_word = 34'h2_1234_5678;
    tick();
    wr_stb = 1'b0;
    chk("post_rst_stb",  64'(rd_stb), 64'd1);
    chk("post_rst_word", 64'(rd_word), 64'h2_1234_5678);
    tick();
    chk("post_rst_empty", 64'(fill), 64'd0);

    // Saturation: 300 writes while full.
    rd_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_stb = 1'b1; wr_word = 34'(500 + i);
      tick();
    end
    for (int i = 0; i < 300; i++) begin
      wr_word = 34'h3_0000_0000 + 34'(i);
      tick();
    end
    wr_stb = 1'b0;
`ifdef CMD_FIFO_OVF_CNT_EN
    exp_cnt = 255;
`else
    exp_cnt = 0;
`endif
    chk("sat_cnt", 64'(ovf_cnt), 64'(exp_cnt));
    chk("sat_ovf", 64'(ovf), 64'd1);
    // Clear coinciding with a drop: flag stays set, count cleared.
    wr_stb = 1'b1; ovf_clear = 1'b1;
    tick();
    wr_stb = 1'b0; ovf_clear = 1'b0;
    chk("clr_drop_ovf", 64'(ovf), 64'd1);
    chk("clr_drop_cnt", 64'(ovf_cnt), 64'd0);
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    chk("clr_ovf", 64'(ovf), 64'd0);
    chk("clr_cnt", 64'(ovf_cnt), 64'd0);
    rd_busy = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("sat_drain_order", 64'(rd_word), 64'(500 + k));
      tick();
    end
    chk("sat_drain_empty", 64'(fill), 64'd0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
